cva6_lsu_occupancy_model: RTL and testbench

- Cycle-level occupancy model of the CVA6 load/store unit, used for equivalence checking against the LSU shim.
- Accepts load/store instructions through a valid/ready handshake.
- Tracks at most one outstanding load and a small in-order store buffer; memory responses retire them.
- Exposes only `ready_o`, which back-pressures the issue stage.

---
 rtl/cva6_lsu_occupancy_model_pkg.sv | 28 ++
 rtl/cva6_lsu_occupancy_model_if.sv | 33 +++
 rtl/cva6_lsu_occupancy_model_store_fifo.sv | 71 +++++++
 rtl/cva6_lsu_occupancy_model.sv | 140 ++++++++++++++
 tb/tb_cva6_lsu_occupancy_model.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/cva6_lsu_occupancy_model_pkg.sv
// Shared types and constants for the CVA6 LSU occupancy model.
// CVA6_LSU_PROTOCOL_CHECK_EN selects whether the simulation protocol checker is built.
package cva6_lsu_model_pkg;

  localparam int unsigned LSU_XLEN                = 32'd32;
  localparam int unsigned DEFAULT_STORE_BUF_DEPTH = 32'd2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_load_state_e;

  typedef struct packed {
    logic [LSU_XLEN-1:0] addr;
  } store_entry_t;

  // A depth-1 buffer still needs a 1-bit pointer so the register is never zero-width.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

`ifdef CVA6_LSU_PROTOCOL_CHECK_EN
  localparam bit PROTOCOL_CHECK_EN = 1'b1;
`else
  localparam bit PROTOCOL_CHECK_EN = 1'b0;
`endif

endpackage

// File: rtl/cva6_lsu_occupancy_model_if.sv
// Issue/response bundle between the issue stage (master) and the LSU model (slave).
interface cva6_lsu_occupancy_model_if
  import cva6_lsu_model_pkg::*;
#(
  parameter int unsigned XLEN = LSU_XLEN
);

  logic [XLEN-1:0] instr_i;
  logic            is_load_i;
  logic            instr_valid_i;
  logic            store_mem_resp_i;
  logic            load_mem_resp_i;
  logic            ready_o;

  modport master (
    output instr_i,
    output is_load_i,
    output instr_valid_i,
    output store_mem_resp_i,
    output load_mem_resp_i,
    input  ready_o
  );

  modport slave (
    input  instr_i,
    input  is_load_i,
    input  instr_valid_i,
    input  store_mem_resp_i,
    input  load_mem_resp_i,
    output ready_o
  );

endinterface

// File: rtl/cva6_lsu_occupancy_model_store_fifo.sv
// In-order circular store buffer: push at the write pointer, pop the oldest entry.
// A pop on an empty buffer and a push on a full buffer are both ignored.
module cva6_lsu_store_fifo
  import cva6_lsu_model_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_STORE_BUF_DEPTH,
  localparam int unsigned PTR_W = ptr_width(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 32'd1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  store_entry_t     push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output store_entry_t     head_o
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  store_entry_t     r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 32'd1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o    = (r_count == CNT_W'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign head_o    = r_mem[r_rd_ptr];
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  // Occupancy update; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer, count and storage registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data_i;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: rtl/cva6_lsu_occupancy_model.sv
// Cycle-level LSU occupancy model: one outstanding load plus an in-order store buffer.
// Defining CVA6_LSU_PROTOCOL_CHECK_EN adds a simulation-only protocol checker.
module cva6_lsu_occupancy_model
  import cva6_lsu_model_pkg::*;
#(
  parameter int unsigned XLEN            = LSU_XLEN,
  parameter int unsigned STORE_BUF_DEPTH = DEFAULT_STORE_BUF_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  cva6_lsu_occupancy_model_if.slave   lsu
);

  localparam int unsigned CNT_W = $clog2(STORE_BUF_DEPTH + 32'd1);

  lsu_load_state_e  r_load_state;
  lsu_load_state_e  w_load_state_nxt;
  logic [XLEN-1:0]  r_load_addr;
  logic             w_ready;
  logic             w_accept;
  logic             w_load_accept;
  logic             w_store_push;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_store_count;
  store_entry_t     w_push_entry;
  store_entry_t     w_store_head;
  logic             w_unused_obs;

  // Ready depends on registered state only, so issue-side inputs never loop back.
  assign w_ready       = (r_load_state == IDLE) && !w_fifo_full;
  assign lsu.ready_o   = w_ready;
  assign w_accept      = lsu.instr_valid_i && w_ready;
  assign w_load_accept = w_accept && lsu.is_load_i;
  assign w_store_push  = w_accept && !lsu.is_load_i;
  assign w_push_entry  = '{addr: lsu.instr_i};

  // Latched addresses are kept for equivalence observation but drive no output.
  assign w_unused_obs  = ^{r_load_addr, w_store_head, w_store_count, w_fifo_empty};

  // Load FSM next state; a load response in IDLE falls through as a no-op.
  always_comb begin
    w_load_state_nxt = r_load_state;
    case (r_load_state)
      IDLE: begin
        if (w_load_accept) begin
          w_load_state_nxt = WAIT;
        end else begin
          w_load_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (lsu.load_mem_resp_i) begin
          w_load_state_nxt = IDLE;
        end else begin
          w_load_state_nxt = WAIT;
        end
      end
      default: w_load_state_nxt = IDLE;
    endcase
  end

  // Load FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_load_state <= IDLE;
    end else begin
      r_load_state <= w_load_state_nxt;
    end
  end

  // Load address latch, captured on load accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_load_addr <= '0;
    end else if (w_load_accept) begin
      r_load_addr <= lsu.instr_i;
    end
  end

  cva6_lsu_store_fifo #(
    .DEPTH (STORE_BUF_DEPTH)
  ) u_store_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_store_push),
    .push_data_i (w_push_entry),
    .pop_i       (lsu.store_mem_resp_i),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty),
    .count_o     (w_store_count),
    .head_o      (w_store_head)
  );

`ifdef CVA6_LSU_PROTOCOL_CHECK_EN
  cva6_lsu_protocol_checker u_protocol_checker (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .load_idle_i        (r_load_state == IDLE),
    .store_empty_i      (w_fifo_empty),
    .instr_valid_i      (lsu.instr_valid_i),
    .is_load_i          (lsu.is_load_i),
    .store_mem_resp_i   (lsu.store_mem_resp_i),
    .load_mem_resp_i    (lsu.load_mem_resp_i)
  );
`endif

endmodule

`ifdef CVA6_LSU_PROTOCOL_CHECK_EN
// Simulation-only protocol checker for responses without a pending op and X opcode.
module cva6_lsu_protocol_checker (
  input logic clk_i,
  input logic rst_i,
  input logic load_idle_i,
  input logic store_empty_i,
  input logic instr_valid_i,
  input logic is_load_i,
  input logic store_mem_resp_i,
  input logic load_mem_resp_i
);

  // Sample protocol violations on each active edge outside reset.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (load_mem_resp_i && load_idle_i) begin
        $error("lsu protocol: load response with no pending load");
      end
      if (store_mem_resp_i && store_empty_i) begin
        $error("lsu protocol: store response with empty store buffer");
      end
      if (instr_valid_i && $isunknown(is_load_i)) begin
        $error("lsu protocol: is_load unknown while instr_valid");
      end
    end
  end

endmodule
`else
`endif

// File: tb/tb_cva6_lsu_occupancy_model.sv
// Directed table-driven bench for the LSU occupancy model plus hand-written corner sequences.
module tb_cva6_lsu_occupancy_model;

  localparam logic [31:0] A = 32'h0000_0cad;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  cva6_lsu_occupancy_model_if #(.XLEN(32)) bus ();

  cva6_lsu_occupancy_model #(
    .XLEN            (32),
    .STORE_BUF_DEPTH (2)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .lsu   (bus)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        vld;
    logic        ld;
    logic        sresp;
    logic        lresp;
    logic [31:0] addr;
    logic        exp;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_exp;
  int   waited;

  task automatic add(input string n, input logic rst, input logic vld, input logic ld,
                     input logic sresp, input logic lresp, input logic [31:0] addr,
                     input logic exp);
    vec_t v;
    v.name = n; v.rst = rst; v.vld = vld; v.ld = ld;
    v.sresp = sresp; v.lresp = lresp; v.addr = addr; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic vld, input logic ld,
                       input logic sresp, input logic lresp, input logic [31:0] addr);
    rst_i                = rst;
    bus.instr_valid_i    = vld;
    bus.is_load_i        = ld;
    bus.store_mem_resp_i = sresp;
    bus.load_mem_resp_i  = lresp;
    bus.instr_i          = addr;
  endtask

  task automatic check(input string n, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: ready_o=%b expected=%b at %0t", n, act, exp, $time);
    end
  endtask

  task automatic check_int(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic vld, input logic ld,
                      input logic sresp, input logic lresp, input logic [31:0] addr,
                      input string n, input logic exp);
    @(negedge clk_i);
    drive(rst, vld, ld, sresp, lresp, addr);
    @(posedge clk_i);
    #1;
    check(n, bus.ready_o, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    //   name              rst   vld   ld    sresp lresp addr   exp
    add("reset",          1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    add("idle",           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    add("spur_lresp",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    add("spur_sresp",     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    add("load_accept",    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A,     1'b0);
    add("store_drop1",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A,     1'b0);
    add("store_drop2",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A,     1'b0);
    add("load_resp",      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    add("store1",         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A,     1'b1);
    add("store2_full",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A,     1'b0);
    add("sresp_1",        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    add("sresp_2",        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    add("sresp_ignored",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    add("refill1",        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A,     1'b1);
    add("refill2_full",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A,     1'b0);
    add("full_push_pop",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, A,     1'b1);
    for (int k = 0; k < 5; k++) begin
      add($sformatf("pushpop_%0d", k), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, A + 32'(k), 1'b1);
    end
    add("drain_to_0",     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    add("cnt0_store1",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A,     1'b1);
    add("cnt0_store2",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A,     1'b0);
    add("drain_a",        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    add("drain_b",        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    add("st_then_ld_st",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A,     1'b1);
    add("st_then_ld_ld",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A,     1'b0);
    add("wait_st_pops",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    add("wait_idle",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    add("wait_lresp",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    add("ldsr_store",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A,     1'b1);
    add("ld_and_sresp",   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, A,     1'b0);
    add("ld_release",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    add("st_and_lresp",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, A,     1'b1);
    add("st_fill",        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A,     1'b0);
    add("pre_rst_pop",    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    add("pre_rst_load",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A,     1'b0);
    add("mid_reset",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    add("post_rst_lresp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    add("post_rst_sresp", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    add("post_rst_st1",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A,     1'b1);
    add("post_rst_st2",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A,     1'b0);
    add("reset_full",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    add("reset_wins_ld",  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, A,     1'b1);
    add("after_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    prev_exp = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      drive(vecs[i].rst, vecs[i].vld, vecs[i].ld, vecs[i].sresp, vecs[i].lresp, vecs[i].addr);
      #1;
      // Ready must not react to this cycle's inputs.
      if (i > 0) check({vecs[i].name, "_pre"}, bus.ready_o, prev_exp);
      @(posedge clk_i);
      #1;
      check(vecs[i].name, bus.ready_o, vecs[i].exp);
      prev_exp = vecs[i].exp;
    end

    // Issuer holds a load while the store buffer is full; it goes in once a store retires.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A,          "hold_fill1", 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A + 32'd4,  "hold_fill2", 1'b0);
    @(negedge clk_i);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A + 32'd8);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i);
      #1;
      check("held_load_blocked", bus.ready_o, 1'b0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, A + 32'd8,  "pop_releases", 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A + 32'd8,  "held_load_taken", 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      "load_pending", 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,      "load_retire", 1'b1);

    // Bounded wait for ready after the load retires; it should already be high.
    @(negedge clk_i);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    waited = 0;
    while (bus.ready_o !== 1'b1 && waited < 10) begin
      @(posedge clk_i);
      #1;
      waited++;
    end
    check_int("ready_wait_cycles", waited, 0);

    // One store remains queued: retire it, then prove the count is back at zero.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,      "final_drain", 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A,          "final_st1", 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, A,          "final_st2", 1'b0);

    @(negedge clk_i);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
